// File: rtl/msx_io_arbiter.sv
// Round-robin arbiter sharing one MSX I/O slave (timer, B0h-B3h) among NUM_REQ masters, with grant lock.
// Optional forced lock release after LOCK_LIMIT idle cycles when ARB_LOCK_TIMEOUT_EN is defined.
module msx_io_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int LOCK_LIMIT = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     s_ioreq,
  input  logic [NUM_REQ*8-1:0]   s_address,
  input  logic [NUM_REQ-1:0]     s_write,
  input  logic [NUM_REQ-1:0]     s_valid,
  input  logic [NUM_REQ-1:0]     s_lock,
  input  logic [NUM_REQ*8-1:0]   s_wdata,
  output logic [NUM_REQ-1:0]     s_ready,
  output logic [7:0]             s_rdata,
  output logic [NUM_REQ-1:0]     s_rdata_en,
  output logic                   m_ioreq,
  output logic [7:0]             m_address,
  output logic                   m_write,
  output logic                   m_valid,
  output logic [7:0]             m_wdata,
  input  logic                   m_ready,
  input  logic [7:0]             m_rdata,
  input  logic                   m_rdata_en,
  output logic [NUM_REQ-1:0]     grant
`ifdef ARB_LOCK_TIMEOUT_EN
  ,
  output logic                   lock_timeout
`endif
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, BUSY, WAIT_RD, LOCKED} state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   owner_reg;
  logic [IDX_W-1:0]   last_reg;
  logic [NUM_REQ-1:0] grant_reg;
  logic               rd_seen_reg;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               owner_valid, owner_write, owner_lock, owner_ioreq;
  logic [7:0]         owner_addr, owner_wdata;
  logic               active, handshake, complete, rd_strobe, timeout_hit;

  // Scan from farthest to nearest after last_reg so the nearest pending index wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(last_reg) + k) % NUM_REQ;
      if (s_valid[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(idx);
      end
    end
  end

  assign owner_valid = s_valid[owner_reg];
  assign owner_write = s_write[owner_reg];
  assign owner_lock  = s_lock[owner_reg];
  assign owner_ioreq = s_ioreq[owner_reg];
  assign owner_addr  = s_address[8*int'(owner_reg) +: 8];
  assign owner_wdata = s_wdata[8*int'(owner_reg) +: 8];

  assign active    = (state_reg == BUSY) || (state_reg == WAIT_RD);
  assign m_valid   = owner_valid && (state_reg == BUSY);
  assign m_ioreq   = active && owner_ioreq;
  assign m_write   = active && owner_write;
  assign m_address = active ? owner_addr  : 8'h00;
  assign m_wdata   = active ? owner_wdata : 8'h00;

  assign handshake = m_ready && m_valid;
  assign rd_strobe = m_rdata_en &&
                     ((state_reg == WAIT_RD) || ((state_reg == BUSY) && !owner_write));
  // A read may finish at the handshake only if its data has already shown up.
  assign complete  = ((state_reg == BUSY) && handshake &&
                      (owner_write || rd_seen_reg || m_rdata_en)) ||
                     ((state_reg == WAIT_RD) && m_rdata_en);

  assign s_rdata = m_rdata;
  assign grant   = grant_reg;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_resp
      assign s_ready[gi]    = handshake && (owner_reg == IDX_W'(gi));
      assign s_rdata_en[gi] = rd_strobe && (owner_reg == IDX_W'(gi));
    end
  endgenerate

`ifdef ARB_LOCK_TIMEOUT_EN
  localparam int CNT_W = $clog2(LOCK_LIMIT + 1);

  logic [CNT_W-1:0] lock_cnt_reg;
  logic             lock_timeout_reg;
  logic             lock_idle;

  assign lock_idle    = (state_reg == LOCKED) && !owner_valid && owner_lock;
  assign timeout_hit  = lock_idle && (lock_cnt_reg == CNT_W'(LOCK_LIMIT - 1));
  assign lock_timeout = lock_timeout_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_cnt_reg     <= '0;
      lock_timeout_reg <= 1'b0;
    end else begin
      lock_timeout_reg <= timeout_hit;
      if (lock_idle && !timeout_hit)
        lock_cnt_reg <= lock_cnt_reg + 1'b1;
      else
        lock_cnt_reg <= '0;
    end
  end
`else
  // Only a degenerate zero limit would ever release; normal builds hold the lock indefinitely.
  assign timeout_hit = (LOCK_LIMIT == 0) && (state_reg == LOCKED) && !owner_valid;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      owner_reg   <= '0;
      last_reg    <= IDX_W'(NUM_REQ - 1);
      grant_reg   <= '0;
      rd_seen_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            owner_reg <= pick_idx;
            last_reg  <= pick_idx;
            grant_reg <= NUM_REQ'(1) << pick_idx;
            state_reg <= BUSY;
          end
        end
        BUSY, WAIT_RD: begin
          if (complete) begin
            rd_seen_reg <= 1'b0;
            if (owner_lock) begin
              state_reg <= LOCKED;
            end else begin
              state_reg <= IDLE;
              grant_reg <= '0;
            end
          end else if (state_reg == BUSY) begin
            if (handshake)
              state_reg <= WAIT_RD;
            else if (m_valid && !owner_write && m_rdata_en)
              rd_seen_reg <= 1'b1;
          end
        end
        LOCKED: begin
          if (owner_valid) begin
            state_reg <= BUSY;
          end else if (!owner_lock || timeout_hit) begin
            state_reg <= IDLE;
            grant_reg <= '0;
          end
        end
        default: begin
          state_reg <= IDLE;
          grant_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msx_io_arbiter.sv
// Directed scoreboard bench for msx_io_arbiter: expected transactions are queued in service order
// and checked against the downstream bus at each handshake.
module tb_msx_io_arbiter;
  localparam int NUM_REQ = 2;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NUM_REQ-1:0]   s_ioreq, s_write, s_valid, s_lock;
  logic [NUM_REQ*8-1:0] s_address, s_wdata;
  logic [NUM_REQ-1:0]   s_ready, s_rdata_en, grant;
  logic [7:0]           s_rdata;
  logic                 m_ioreq, m_write, m_valid;
  logic [7:0]           m_address, m_wdata;
  logic                 m_ready, m_rdata_en;
  logic [7:0]           m_rdata;
`ifdef ARB_LOCK_TIMEOUT_EN
  logic                 lock_timeout;
`endif

  int tests  = 0;
  int failed = 0;

  typedef struct {
    int         req;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    int         rd_delay;
  } txn_t;
  txn_t sb[$];

  msx_io_arbiter #(.NUM_REQ(NUM_REQ), .LOCK_LIMIT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_ioreq(s_ioreq), .s_address(s_address), .s_write(s_write),
    .s_valid(s_valid), .s_lock(s_lock), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata), .s_rdata_en(s_rdata_en),
    .m_ioreq(m_ioreq), .m_address(m_address), .m_write(m_write),
    .m_valid(m_valid), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .m_rdata_en(m_rdata_en),
    .grant(grant)
`ifdef ARB_LOCK_TIMEOUT_EN
    , .lock_timeout(lock_timeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [7:0] addr,
                         input logic [7:0] data, input logic lock);
    s_ioreq[i]          = 1'b1;
    s_write[i]          = wr;
    s_address[i*8 +: 8] = addr;
    s_wdata[i*8 +: 8]   = data;
    s_lock[i]           = lock;
    s_valid[i]          = 1'b1;
  endtask

  // For reads, data holds the value the slave returns and rd_delay the cycles from ready to rdata_en.
  task automatic expect_txn(input int i, input logic wr, input logic [7:0] addr,
                            input logic [7:0] data, input int rd_delay);
    txn_t t;
    t.req = i; t.wr = wr; t.addr = addr; t.data = data; t.rd_delay = rd_delay;
    sb.push_back(t);
  endtask

  // Plays the slave for one transaction and compares it against the head of the scoreboard.
  task automatic xfer();
    txn_t t;
    int   waited;
    logic [31:0] exp_grant;
    #1;
    if (sb.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL sb_underflow observed=empty expected=entry");
      return;
    end
    t = sb.pop_front();
    exp_grant = 32'(1) << t.req;
    waited = 0;
    while (m_valid !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    check("m_valid_seen", 32'(m_valid), 32'd1);
    check("owner_grant", 32'(grant), exp_grant);
    check("m_ioreq", 32'(m_ioreq), 32'd1);
    check("m_address", 32'(m_address), 32'(t.addr));
    check("m_write", 32'(m_write), 32'(t.wr));
    if (t.wr) check("m_wdata", 32'(m_wdata), 32'(t.data));
    m_ready = 1'b1;
    if (!t.wr && t.rd_delay == 0) begin
      m_rdata_en = 1'b1;
      m_rdata    = t.data;
    end
    #1;
    check("s_ready", 32'(s_ready), exp_grant);
    if (!t.wr && t.rd_delay == 0) begin
      check("s_rdata_en_now", 32'(s_rdata_en), exp_grant);
      check("s_rdata_now", 32'(s_rdata), 32'(t.data));
    end
    $display("[TB] xfer req%0d %s addr=%02h data=%02h grant=%b", t.req,
             t.wr ? "wr" : "rd", t.addr, t.data, grant);
    tick();
    m_ready    = 1'b0;
    m_rdata_en = 1'b0;
    s_valid[t.req] = 1'b0;
    if (!t.wr && t.rd_delay > 0) begin
      #1;
      check("wait_rd_grant", 32'(grant), exp_grant);
      check("wait_rd_m_valid", 32'(m_valid), 32'd0);
      check("wait_rd_no_strobe", 32'(s_rdata_en), 32'd0);
      for (int i = 1; i < t.rd_delay; i++) tick();
      m_rdata_en = 1'b1;
      m_rdata    = t.data;
      #1;
      check("s_rdata_en_late", 32'(s_rdata_en), exp_grant);
      check("s_rdata_late", 32'(s_rdata), 32'(t.data));
      tick();
      m_rdata_en = 1'b0;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    s_ioreq = '0; s_write = '0; s_valid = '0; s_lock = '0;
    s_address = '0; s_wdata = '0;
    m_ready = 1'b0; m_rdata_en = 1'b0; m_rdata = 8'h5A;
    #2;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_ioreq", 32'(m_ioreq), 32'd0);
    check("rst_m_address", 32'(m_address), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_s_rdata_en", 32'(s_rdata_en), 32'd0);
    check("rst_s_rdata_pass", 32'(s_rdata), 32'h5A);
    tick();
    reset_n = 1'b1;
    tick();

    // Two simultaneous pairs: both go req0 then req1
    for (int p = 0; p < 2; p++) begin
      set_req(0, 1'b1, 8'hB0, 8'h10 + 8'(p), 1'b0);
      set_req(1, 1'b1, 8'hB1, 8'h20 + 8'(p), 1'b0);
      expect_txn(0, 1'b1, 8'hB0, 8'h10 + 8'(p), 0);
      expect_txn(1, 1'b1, 8'hB1, 8'h20 + 8'(p), 0);
      xfer();
      #1;
      check("pair_idle_between", 32'(grant), 32'd0);
      xfer();
    end

    // Single write with one-cycle arbitration latency
    tick();
    set_req(0, 1'b1, 8'hB1, 8'h0A, 1'b0);
    expect_txn(0, 1'b1, 8'hB1, 8'h0A, 0);
    #1;
    check("single_idle_grant", 32'(grant), 32'd0);
    check("single_idle_m_valid", 32'(m_valid), 32'd0);
    tick();
    check("single_grant_latency", 32'(grant), 32'b01);
    xfer();
    #1;
    check("single_release", 32'(grant), 32'd0);

    // Lock pair by req1 while req0 keeps requesting
    tick();
    set_req(1, 1'b1, 8'hB0, 8'h06, 1'b1);
    expect_txn(1, 1'b1, 8'hB0, 8'h06, 0);
    tick();
    set_req(0, 1'b1, 8'hB1, 8'h55, 1'b0);
    xfer();
    #1;
    check("locked_grant", 32'(grant), 32'b10);
    check("locked_m_valid", 32'(m_valid), 32'd0);
    check("locked_m_ioreq", 32'(m_ioreq), 32'd0);
    set_req(1, 1'b1, 8'hB1, 8'h03, 1'b0);
    expect_txn(1, 1'b1, 8'hB1, 8'h03, 0);
    expect_txn(0, 1'b1, 8'hB1, 8'h55, 0);
    xfer();
    xfer();

    // Read with data three cycles after ready, then read with data alongside ready
    tick();
    set_req(0, 1'b0, 8'hB3, 8'h00, 1'b0);
    expect_txn(0, 1'b0, 8'hB3, 8'h0A, 3);
    xfer();
    #1;
    check("read_late_release", 32'(grant), 32'd0);
    set_req(1, 1'b0, 8'hB2, 8'h00, 1'b0);
    expect_txn(1, 1'b0, 8'hB2, 8'hC3, 0);
    xfer();
    #1;
    check("read_now_release", 32'(grant), 32'd0);

`ifdef ARB_LOCK_TIMEOUT_EN
    // Lock held with no traffic is broken after LOCK_LIMIT cycles
    tick();
    set_req(0, 1'b1, 8'hB0, 8'h07, 1'b1);
    expect_txn(0, 1'b1, 8'hB0, 8'h07, 0);
    tick();
    set_req(1, 1'b1, 8'hB1, 8'h77, 1'b0);
    xfer();
    #1;
    for (int i = 0; i < 8; i++) begin
      check("to_locked_grant", 32'(grant), 32'b01);
      check("to_no_pulse", 32'(lock_timeout), 32'd0);
      tick();
    end
    check("to_pulse", 32'(lock_timeout), 32'd1);
    check("to_grant_cleared", 32'(grant), 32'd0);
    tick();
    check("to_pulse_single", 32'(lock_timeout), 32'd0);
    check("to_next_grant", 32'(grant), 32'b10);
    expect_txn(1, 1'b1, 8'hB1, 8'h77, 0);
    xfer();
    s_lock[0] = 1'b0;
`else
    // Lock held with no traffic persists until s_lock drops
    tick();
    set_req(0, 1'b1, 8'hB0, 8'h07, 1'b1);
    expect_txn(0, 1'b1, 8'hB0, 8'h07, 0);
    tick();
    set_req(1, 1'b1, 8'hB1, 8'h77, 1'b0);
    xfer();
    #1;
    for (int i = 0; i < 20; i++) begin
      check("hold_locked_grant", 32'(grant), 32'b01);
      tick();
    end
    s_lock[0] = 1'b0;
    tick();
    check("hold_released", 32'(grant), 32'd0);
    expect_txn(1, 1'b1, 8'hB1, 8'h77, 0);
    xfer();
`endif

    // Reset while waiting for read data
    tick();
    set_req(0, 1'b0, 8'hB3, 8'h00, 1'b0);
    tick();
    check("rr_grant", 32'(grant), 32'b01);
    m_ready = 1'b1;
    #1;
    check("rr_s_ready", 32'(s_ready), 32'b01);
    tick();
    m_ready = 1'b0;
    s_valid[0] = 1'b0;
    #1;
    check("rr_wait_ioreq", 32'(m_ioreq), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rr_reset_grant", 32'(grant), 32'd0);
    check("rr_reset_ioreq", 32'(m_ioreq), 32'd0);
    check("rr_reset_m_valid", 32'(m_valid), 32'd0);
    set_req(1, 1'b1, 8'hB2, 8'h99, 1'b0);
    set_req(0, 1'b1, 8'hB0, 8'h11, 1'b0);
    expect_txn(0, 1'b1, 8'hB0, 8'h11, 0);
    expect_txn(1, 1'b1, 8'hB2, 8'h99, 0);
    tick();
    reset_n = 1'b1;
    xfer();
    xfer();

    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("final_grant", 32'(grant), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
